// File: rtl/lfsr_rand8.sv
// lfsr_rand8 -- 8-bit maximal-length Fibonacci LFSR pseudo-random source.
// Taps 8,6,5,4 (x^8+x^6+x^5+x^4+1) give a 255-state period over the
// nonzero values. q_mod gives consumers a bounded value such as a letter
// index, and wrap marks the start of each period.
module lfsr_rand8 #(
  parameter logic [7:0]  SEED = 8'h01,  // reset/reload state, must be nonzero
  parameter int unsigned MOD  = 26      // modulus for q_mod, 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] seed_in,
  output logic [7:0] q,
  output logic [7:0] q_mod,
  output logic       wrap
);

  localparam logic [7:0] MOD_C = 8'(MOD);

  logic [7:0] s_q;
  logic [7:0] s_d;
  logic       fb;

  // Next-state selection: hold, reload (never all-zero), or shift.
  always_comb begin
    // NOTE: s_d gets a default first so that no path leaves it unassigned,
    // which would otherwise infer a latch.
    s_d = s_q;
    fb  = s_q[7] ^ s_q[5] ^ s_q[4] ^ s_q[3];
    if (en) begin
      if (load) begin
        // A zero seed would lock the LFSR up; fall back to SEED instead.
        s_d = (seed_in != 8'h00) ? seed_in : SEED;
      end else begin
        s_d = {s_q[6:0], fb};
      end
    end
  end

  // State register; reset forces SEED immediately, without a clock.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values.
    if (reset) s_q <= SEED;
    else       s_q <= s_d;
  end

  // Outputs are pure functions of the state register.
  assign q     = s_q;
  assign q_mod = s_q % MOD_C;
  assign wrap  = (s_q == SEED);

endmodule

// File: tb/tb_lfsr_rand8.sv
// Self-checking bench for lfsr_rand8 (SEED=01, MOD=26). The bench keeps
// its own model of the LFSR, pushes the expected outputs to a scoreboard
// when it drives an edge, and pops and compares them once the edge has
// happened. The test plan values are also checked against literal constants.
module tb_lfsr_rand8;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [7:0] seed_in;
  logic [7:0] q;
  logic [7:0] q_mod;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic [7:0] qm;
    logic [7:0] wr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_s;

  lfsr_rand8 #(.SEED(8'h01), .MOD(26)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .seed_in (seed_in),
    .q       (q),
    .q_mod   (q_mod),
    .wrap    (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
  endtask

  // Expected outputs for the current model state.
  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.q   = model_s;
    e.qm  = 8'(model_s % 8'd26);
    e.wr  = {7'd0, model_s == 8'h01};
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 8'h01, 8'h00);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".q"},     q,              e.q);
      check({e.tag, ".q_mod"}, q_mod,          e.qm);
      check({e.tag, ".wrap"},  {7'd0, wrap},   e.wr);
    end
  endtask

  // Drive one clock edge, update the model, then compare after the edge.
  task automatic step(input logic e_i, input logic l_i, input logic [7:0] sd_i,
                      input string tag);
    en      = e_i;
    load    = l_i;
    seed_in = sd_i;
    if (e_i) begin
      if (l_i) model_s = (sd_i != 8'h00) ? sd_i : 8'h01;
      else     model_s = {model_s[6:0], model_s[7] ^ model_s[5] ^ model_s[4] ^ model_s[3]};
    end
    push_exp(tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Reset pulse between edges; leaves the model at SEED.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    model_s = 8'h01;
    push_exp("reset_pulse");
    pop_check();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] shift_exp [7];
    logic       seen [256];
    int         n;

    shift_exp = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};

    // Reset before any clock edge.
    reset   = 1'b1;
    en      = 1'b1;
    load    = 1'b0;
    seed_in = 8'h00;
    #2;
    check("async_reset.q",     q,            8'h01);
    check("async_reset.wrap",  {7'd0, wrap}, 8'h01);
    check("async_reset.q_mod", q_mod,        8'h01);

    // Reset held with en=1 and load=1 overrides both.
    load    = 1'b1;
    seed_in = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold.q", q, 8'h01);
    end
    reset   = 1'b0;
    load    = 1'b0;
    model_s = 8'h01;

    // Shift sequence of seven enabled edges.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 8'h00, "shift");
      check("shift_const", q, shift_exp[i]);
    end
    check("shift_8e.q_mod", q_mod,        8'd12);
    check("shift_8e.wrap",  {7'd0, wrap}, 8'h00);

    // Enable gating: load must be ignored while en=0.
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, "gate_pre");
    check("gate_at_08", q, 8'h08);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, i[0], 8'hC3, "gate_hold");
      check("gate_hold_const", q, 8'h08);
    end
    step(1'b1, 1'b0, 8'h00, "gate_resume");
    check("gate_resume_const", q, 8'h11);

    // Load, shift from the loaded value, and zero-seed fallback.
    step(1'b1, 1'b1, 8'hA5, "load_a5");
    check("load_a5_const", q, 8'hA5);
    step(1'b1, 1'b0, 8'h00, "shift_after_load");
    check("shift_after_load_const", q, 8'h4A);
    step(1'b1, 1'b1, 8'h00, "load_zero");
    check("load_zero_const", q, 8'h01);
    check("load_zero.wrap", {7'd0, wrap}, 8'h01);

    // Full period from reset: count enabled edges until wrap returns.
    pulse_reset();
    foreach (seen[i]) seen[i] = 1'b0;
    seen[1] = 1'b1;
    n = 0;
    while (n < 300) begin
      step(1'b1, 1'b0, 8'h00, "period");
      n++;
      if (wrap) break;
      check("period.nonzero",  {7'd0, q == 8'h00},    8'h00);
      check("period.norepeat", {7'd0, seen[q]},      8'h00);
      check("period.qmod_lt",  {7'd0, q_mod >= 8'd26}, 8'h00);
      seen[q] = 1'b1;
    end
    check("period.length", 8'(n), 8'd255);
    check("period.end_q",  q,     8'h01);

    // Async reset between edges after 40 shifts.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'h00, "pre_reset");
    #2 reset = 1'b1;
    #1;
    check("midrun_reset.q",    q,            8'h01);
    check("midrun_reset.wrap", {7'd0, wrap}, 8'h01);
    reset   = 1'b0;
    model_s = 8'h01;
    step(1'b1, 1'b0, 8'h00, "after_reset");
    check("after_reset_const", q, 8'h02);

    check("scoreboard_drained", 8'(sb.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
